spw_pio_fifo_bridge: RTL and testbench
======================================

SPW_PIO_FIFO_BRIDGE -- requirements
Module: spw_pio_fifo_bridge

Interface
REQ-001 Parameter DEPTH, default 32, entries per FIFO (power of two, 4..64).
REQ-002 Parameter CW, default 6, FIFO count width; SHALL equal log2(DEPTH)+1.
REQ-003 clock  in  1  single system clock; all logic rising-edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 transmitfifodatain  in  9  PIO TX word; bit8=control flag, bits7:0 data.
REQ-006 transmitfifowriteenable  in  1  PIO TX strobe level; a 0->1 transition pushes one word.
REQ-007 transmitfifofull  out  1  TX FIFO full.
REQ-008 transmitfifodatacount  out  CW  TX FIFO occupancy.
REQ-009 txdata / txvalid / txready  out 9 / out 1 / in 1  codec-side TX stream.
REQ-010 rxdata / rxvalid / rxready  in 9 / in 1 / out 1  codec-side RX stream.
REQ-011 receivefiforeadenable  in  1  PIO RX strobe level; a 0->1 transition pops one word.
REQ-012 receivefifodataout  out  9  RX FIFO head word (first-word-fall-through).
REQ-013 receivefifoempty / receivefifofull  out  1 each  RX FIFO flags.
REQ-014 receivefifodatacount  out  CW  RX FIFO occupancy.
REQ-015 overflowclear  in  1  clears sticky error flags.
REQ-016 txoverflow / rxunderflow  out  1 each  sticky: PIO push while TX full / PIO pop while RX empty.

Function
REQ-017 Each strobe SHALL pass through an edge detector (one register holding previous level); the event SHALL be asserted one clock after the 0->1 input change.
REQ-018 A TX event with TX not full SHALL write transmitfifodatain as sampled in the event cycle; count +1 next clock.
REQ-019 A TX event with TX full SHALL drop the word and set txoverflow.
REQ-020 txvalid SHALL equal TX-not-empty; txdata SHALL equal TX head; a word SHALL be popped in every cycle where txvalid and txready are both 1.
REQ-021 rxready SHALL equal RX-not-full; a word SHALL be written in every cycle where rxvalid and rxready are both 1.
REQ-022 An RX event with RX not empty SHALL pop the head; receivefifodataout SHALL show the next word one clock later.
REQ-023 An RX event with RX empty SHALL leave state unchanged and set rxunderflow.
REQ-024 Simultaneous push and pop on one FIFO SHALL leave the count unchanged and both operations SHALL take effect; when full, the push is blocked regardless of a same-cycle pop.
REQ-025 Pointers SHALL wrap modulo DEPTH; count ranges 0..DEPTH inclusive; full = (count==DEPTH), empty = (count==0).
REQ-026 overflowclear SHALL clear both sticky flags next clock; a same-cycle set SHALL win over clear.
REQ-027 Data SHALL pass unmodified in both directions; bit8 SHALL be carried transparently.

Reset
REQ-028 On reset: both FIFOs empty, counts 0, empty flags 1, full flags 0, txvalid 0, rxready 0 (asserted at the first clock after release), sticky flags 0, receivefifodataout 0.
REQ-029 Edge-detector registers SHALL reset to 1 so a strobe held high through reset generates no event.
REQ-030 Reset asserted mid-transfer SHALL discard all FIFO contents immediately.

Structure
REQ-031 Package spw_pio_pkg SHALL hold the 9-bit word width, control-flag bit index, and EOP/EEP codes (0x100, 0x101).
REQ-032 One sub-module spw_sync_fifo (FWFT, count/full/empty outputs) SHALL be instantiated twice.

Verification
REQ-033 Reset with both strobes held 1, then release -> no push or pop; counts stay 0; txoverflow and rxunderflow stay 0.
REQ-034 Three PIO pushes 0x041, 0x042, 0x100 with txready=0 -> transmitfifodatacount=3; then txready=1 -> txdata 0x041, 0x042, 0x100 on consecutive clocks, txvalid falls after the third.
REQ-035 With txready=0, 33 pushes at DEPTH=32 -> transmitfifofull=1, count=32, txoverflow=1; overflowclear pulse -> txoverflow=0.
REQ-036 rxvalid held 1 for 40 cycles, data 0..39 -> rxready drops after 32 accepted, receivefifofull=1; 32 PIO pops -> dataout 0..31 in order, empty=1; a 33rd pop -> rxunderflow=1.
REQ-037 RX count=5, codec write and PIO pop in the same cycle -> count stays 5, head advances by one word.
REQ-038 Reset pulse with TX count=10 and RX count=7 -> both counts 0, empty=1, txvalid=0 immediately.

Source files
------------

// File: rtl/spw_pio_pkg.sv
// Shared word format for the SpaceWire PIO bridge: 9-bit words, bit 8 flags a control code.
package spw_pio_pkg;

    localparam int WORD_W   = 9;
    localparam int CTRL_BIT = 8;

    typedef logic [WORD_W-1:0] word_t;

    localparam word_t EOP = 9'h100;
    localparam word_t EEP = 9'h101;

    function automatic logic is_ctrl(input word_t w);
        return w[CTRL_BIT];
    endfunction

endpackage

// File: rtl/spw_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count and full/empty flags.
// Latency: a write is visible at rd_dat one clock later; a pop shows the next word one clock later.
// Backpressure: writes are ignored when full and pops are ignored when empty, even if the other side is active.
module spw_sync_fifo
    import spw_pio_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int CW    = 6
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          wr_en,
    input  word_t         wr_dat,
    input  logic          rd_en,
    output word_t         rd_dat,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    localparam int AW = CW - 1;

    word_t         mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    assign full   = (count == CW'(DEPTH));
    assign empty  = (count == '0);
    assign push   = wr_en & ~full;
    assign pop    = rd_en & ~empty;
    // Head reads as zero when empty so the PIO side never sees stale memory.
    assign rd_dat = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= wr_dat;
    end

endmodule

// File: rtl/spw_pio_fifo_bridge.sv
// Bridges PIO strobe-driven FIFO access to the SpaceWire codec valid/ready streams.
// Latency: a PIO strobe edge acts on the following clock edge; codec handshakes act every clock.
// Backpressure: txvalid follows TX occupancy, rxready follows RX space; PIO misuse sets sticky flags.
module spw_pio_fifo_bridge
    import spw_pio_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int CW    = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [WORD_W-1:0] transmitfifodatain,
    input  logic              transmitfifowriteenable,
    output logic              transmitfifofull,
    output logic [CW-1:0]     transmitfifodatacount,
    output logic [WORD_W-1:0] txdata,
    output logic              txvalid,
    input  logic              txready,
    input  logic [WORD_W-1:0] rxdata,
    input  logic              rxvalid,
    output logic              rxready,
    input  logic              receivefiforeadenable,
    output logic [WORD_W-1:0] receivefifodataout,
    output logic              receivefifoempty,
    output logic              receivefifofull,
    output logic [CW-1:0]     receivefifodatacount,
    input  logic              overflowclear,
    output logic              txoverflow,
    output logic              rxunderflow
);

    logic tx_we_prev;
    logic rx_re_prev;
    logic rx_en;
    logic tx_evt;
    logic rx_evt;
    logic tx_empty;

    assign tx_evt  = transmitfifowriteenable & ~tx_we_prev;
    assign rx_evt  = receivefiforeadenable & ~rx_re_prev;
    assign txvalid = ~tx_empty;
    // rx_en keeps rxready low through reset and raises it on the first clock after release.
    assign rxready = rx_en & ~receivefifofull;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tx_we_prev  <= 1'b1;
            rx_re_prev  <= 1'b1;
            rx_en       <= 1'b0;
            txoverflow  <= 1'b0;
            rxunderflow <= 1'b0;
        end else begin
            tx_we_prev  <= transmitfifowriteenable;
            rx_re_prev  <= receivefiforeadenable;
            rx_en       <= 1'b1;
            txoverflow  <= (tx_evt & transmitfifofull) | (txoverflow & ~overflowclear);
            rxunderflow <= (rx_evt & receivefifoempty) | (rxunderflow & ~overflowclear);
        end
    end

    spw_sync_fifo #(.DEPTH(DEPTH), .CW(CW)) u_tx_fifo (
        .clock  (clock),
        .reset  (reset),
        .wr_en  (tx_evt),
        .wr_dat (transmitfifodatain),
        .rd_en  (txready),
        .rd_dat (txdata),
        .count  (transmitfifodatacount),
        .full   (transmitfifofull),
        .empty  (tx_empty)
    );

    spw_sync_fifo #(.DEPTH(DEPTH), .CW(CW)) u_rx_fifo (
        .clock  (clock),
        .reset  (reset),
        .wr_en  (rxvalid & rxready),
        .wr_dat (rxdata),
        .rd_en  (rx_evt),
        .rd_dat (receivefifodataout),
        .count  (receivefifodatacount),
        .full   (receivefifofull),
        .empty  (receivefifoempty)
    );

endmodule

// File: tb/tb_spw_pio_fifo_bridge.sv
// Directed bench for spw_pio_fifo_bridge: a vector table of single-edge operations
// followed by hand-written sequences for reset, fill/drain, overflow and underflow.
module tb_spw_pio_fifo_bridge;
    import spw_pio_pkg::*;

    localparam int DEPTH = 32;
    localparam int CW    = 6;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [8:0]    transmitfifodatain = '0;
    logic          transmitfifowriteenable = 1'b0;
    logic          transmitfifofull;
    logic [CW-1:0] transmitfifodatacount;
    logic [8:0]    txdata;
    logic          txvalid;
    logic          txready = 1'b0;
    logic [8:0]    rxdata = '0;
    logic          rxvalid = 1'b0;
    logic          rxready;
    logic          receivefiforeadenable = 1'b0;
    logic [8:0]    receivefifodataout;
    logic          receivefifoempty;
    logic          receivefifofull;
    logic [CW-1:0] receivefifodatacount;
    logic          overflowclear = 1'b0;
    logic          txoverflow;
    logic          rxunderflow;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    spw_pio_fifo_bridge #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clock                   (clock),
        .reset                   (reset),
        .transmitfifodatain      (transmitfifodatain),
        .transmitfifowriteenable (transmitfifowriteenable),
        .transmitfifofull        (transmitfifofull),
        .transmitfifodatacount   (transmitfifodatacount),
        .txdata                  (txdata),
        .txvalid                 (txvalid),
        .txready                 (txready),
        .rxdata                  (rxdata),
        .rxvalid                 (rxvalid),
        .rxready                 (rxready),
        .receivefiforeadenable   (receivefiforeadenable),
        .receivefifodataout      (receivefifodataout),
        .receivefifoempty        (receivefifoempty),
        .receivefifofull         (receivefifofull),
        .receivefifodatacount    (receivefifodatacount),
        .overflowclear           (overflowclear),
        .txoverflow              (txoverflow),
        .rxunderflow             (rxunderflow)
    );

    typedef struct {
        logic       tx_push;
        logic [8:0] tx_dat;
        logic       tx_rdy;
        logic       rx_vld;
        logic [8:0] rx_dat;
        logic       rx_pop;
        int         exp_tx_cnt;
        logic       exp_txvalid;
        logic [8:0] exp_txdata;
        int         exp_rx_cnt;
        logic [8:0] exp_rx_dout;
        logic       exp_rx_empty;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tx_push(input logic [8:0] w);
        @(negedge clock);
        transmitfifodatain      = w;
        transmitfifowriteenable = 1'b1;
        @(negedge clock);
        transmitfifowriteenable = 1'b0;
    endtask

    task automatic rx_pop(input logic [8:0] exp_head);
        @(negedge clock);
        chk("rx_head_before_pop", 32'(receivefifodataout), 32'(exp_head));
        receivefiforeadenable = 1'b1;
        @(negedge clock);
        receivefiforeadenable = 1'b0;
    endtask

    task automatic rx_write(input logic [8:0] w);
        @(negedge clock);
        rxdata  = w;
        rxvalid = 1'b1;
        @(negedge clock);
        rxvalid = 1'b0;
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int acc;

        //             push dat     rdy  vld  rxdat    pop   txc v  txd     rxc dout    emp
        vecs[0] = '{1'b1, 9'h0A5, 1'b0, 1'b0, 9'h000, 1'b0, 1, 1'b1, 9'h0A5, 0, 9'h000, 1'b1};
        vecs[1] = '{1'b1, EEP,    1'b0, 1'b0, 9'h000, 1'b0, 2, 1'b1, 9'h0A5, 0, 9'h000, 1'b1};
        vecs[2] = '{1'b0, 9'h000, 1'b1, 1'b0, 9'h000, 1'b0, 1, 1'b1, EEP,    0, 9'h000, 1'b1};
        vecs[3] = '{1'b1, 9'h03C, 1'b1, 1'b0, 9'h000, 1'b0, 1, 1'b1, 9'h03C, 0, 9'h000, 1'b1};
        vecs[4] = '{1'b0, 9'h000, 1'b0, 1'b1, 9'h1FF, 1'b0, 1, 1'b1, 9'h03C, 1, 9'h1FF, 1'b0};
        vecs[5] = '{1'b0, 9'h000, 1'b0, 1'b1, 9'h055, 1'b0, 1, 1'b1, 9'h03C, 2, 9'h1FF, 1'b0};
        vecs[6] = '{1'b0, 9'h000, 1'b0, 1'b0, 9'h000, 1'b1, 1, 1'b1, 9'h03C, 1, 9'h055, 1'b0};
        vecs[7] = '{1'b0, 9'h000, 1'b0, 1'b1, EOP,    1'b1, 1, 1'b1, 9'h03C, 1, EOP,    1'b0};
        vecs[8] = '{1'b0, 9'h000, 1'b1, 1'b0, 9'h000, 1'b0, 0, 1'b0, 9'h000, 1, EOP,    1'b0};
        vecs[9] = '{1'b0, 9'h000, 1'b0, 1'b0, 9'h000, 1'b1, 0, 1'b0, 9'h000, 0, 9'h000, 1'b1};

        // Reset with both strobes held high: no events may be produced.
        transmitfifowriteenable = 1'b1;
        receivefiforeadenable   = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        chk("rst_tx_count", 32'(transmitfifodatacount), 0);
        chk("rst_rx_count", 32'(receivefifodatacount), 0);
        chk("rst_txvalid", 32'(txvalid), 0);
        chk("rst_rxready", 32'(rxready), 0);
        chk("rst_rx_empty", 32'(receivefifoempty), 1);
        chk("rst_rx_full", 32'(receivefifofull), 0);
        chk("rst_tx_full", 32'(transmitfifofull), 0);
        chk("rst_rx_dout", 32'(receivefifodataout), 0);
        chk("rst_txoverflow", 32'(txoverflow), 0);
        chk("rst_rxunderflow", 32'(rxunderflow), 0);
        reset = 1'b0;
        #1;
        chk("rxready_low_before_first_clock", 32'(rxready), 0);
        repeat (4) @(negedge clock);
        chk("held_strobe_tx_count", 32'(transmitfifodatacount), 0);
        chk("held_strobe_rx_count", 32'(receivefifodatacount), 0);
        chk("held_strobe_txoverflow", 32'(txoverflow), 0);
        chk("held_strobe_rxunderflow", 32'(rxunderflow), 0);
        chk("rxready_after_release", 32'(rxready), 1);
        transmitfifowriteenable = 1'b0;
        receivefiforeadenable   = 1'b0;
        @(posedge clock);

        // Vector table: each row is exactly one active clock edge.
        foreach (vecs[i]) begin
            @(negedge clock);
            transmitfifodatain      = vecs[i].tx_dat;
            transmitfifowriteenable = vecs[i].tx_push;
            txready                 = vecs[i].tx_rdy;
            rxdata                  = vecs[i].rx_dat;
            rxvalid                 = vecs[i].rx_vld;
            receivefiforeadenable   = vecs[i].rx_pop;
            @(negedge clock);
            chk($sformatf("vec%0d_tx_count", i), 32'(transmitfifodatacount), 32'(vecs[i].exp_tx_cnt));
            chk($sformatf("vec%0d_txvalid", i), 32'(txvalid), 32'(vecs[i].exp_txvalid));
            if (vecs[i].exp_txvalid)
                chk($sformatf("vec%0d_txdata", i), 32'(txdata), 32'(vecs[i].exp_txdata));
            chk($sformatf("vec%0d_rx_count", i), 32'(receivefifodatacount), 32'(vecs[i].exp_rx_cnt));
            chk($sformatf("vec%0d_rx_dout", i), 32'(receivefifodataout), 32'(vecs[i].exp_rx_dout));
            chk($sformatf("vec%0d_rx_empty", i), 32'(receivefifoempty), 32'(vecs[i].exp_rx_empty));
            transmitfifowriteenable = 1'b0;
            txready                 = 1'b0;
            rxvalid                 = 1'b0;
            receivefiforeadenable   = 1'b0;
            @(posedge clock);
        end
        chk("table_txoverflow", 32'(txoverflow), 0);
        chk("table_rxunderflow", 32'(rxunderflow), 0);

        // Three pushes held back, then drained on consecutive clocks.
        tx_push(9'h041);
        tx_push(9'h042);
        tx_push(EOP);
        @(negedge clock);
        chk("three_push_count", 32'(transmitfifodatacount), 3);
        txready = 1'b1;
        chk("drain_word0", 32'(txdata), 32'h041);
        @(negedge clock);
        chk("drain_word1", 32'(txdata), 32'h042);
        @(negedge clock);
        chk("drain_word2", 32'(txdata), 32'h100);
        chk("drain_valid2", 32'(txvalid), 1);
        @(negedge clock);
        chk("drain_valid_after", 32'(txvalid), 0);
        txready = 1'b0;

        // TX fill to DEPTH, one extra push overflows.
        for (int k = 0; k < DEPTH; k++) tx_push(9'(k));
        @(negedge clock);
        chk("tx_full_flag", 32'(transmitfifofull), 1);
        chk("tx_full_count", 32'(transmitfifodatacount), 32);
        chk("tx_no_overflow_yet", 32'(txoverflow), 0);
        tx_push(9'h1AA);
        @(negedge clock);
        chk("tx_overflow_set", 32'(txoverflow), 1);
        chk("tx_count_after_drop", 32'(transmitfifodatacount), 32);
        overflowclear = 1'b1;
        @(negedge clock);
        overflowclear = 1'b0;
        chk("tx_overflow_cleared", 32'(txoverflow), 0);
        txready = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            chk($sformatf("tx_drain_%0d", k), 32'(txdata), k);
            @(negedge clock);
        end
        txready = 1'b0;
        chk("tx_drained_valid", 32'(txvalid), 0);
        chk("tx_drained_count", 32'(transmitfifodatacount), 0);

        // RX stream held valid for 40 cycles; only DEPTH words fit.
        acc = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            rxdata  = 9'(k);
            rxvalid = 1'b1;
            if (rxready) acc++;
        end
        @(negedge clock);
        rxvalid = 1'b0;
        chk("rx_accepted", 32'(acc), 32);
        chk("rx_ready_dropped", 32'(rxready), 0);
        chk("rx_full_flag", 32'(receivefifofull), 1);
        chk("rx_full_count", 32'(receivefifodatacount), 32);
        for (int k = 0; k < DEPTH; k++) rx_pop(9'(k));
        @(negedge clock);
        chk("rx_empty_after_pops", 32'(receivefifoempty), 1);
        chk("rx_no_underflow_yet", 32'(rxunderflow), 0);
        rx_pop(9'h000);
        @(negedge clock);
        chk("rx_underflow_set", 32'(rxunderflow), 1);
        chk("rx_count_after_underflow", 32'(receivefifodatacount), 0);
        overflowclear = 1'b1;
        @(negedge clock);
        overflowclear = 1'b0;
        chk("rx_underflow_cleared", 32'(rxunderflow), 0);

        // Simultaneous codec write and PIO pop at count 5.
        for (int k = 0; k < 5; k++) rx_write(9'(9'h020 + k));
        @(negedge clock);
        chk("rx_count_5", 32'(receivefifodatacount), 5);
        chk("rx_head_20", 32'(receivefifodataout), 32'h020);
        rxdata                = 9'h025;
        rxvalid               = 1'b1;
        receivefiforeadenable = 1'b1;
        @(negedge clock);
        rxvalid               = 1'b0;
        receivefiforeadenable = 1'b0;
        chk("rx_simul_count", 32'(receivefifodatacount), 5);
        chk("rx_simul_head", 32'(receivefifodataout), 32'h021);
        for (int k = 1; k < 6; k++) rx_pop(9'(9'h020 + k));
        @(negedge clock);
        chk("rx_simul_drained", 32'(receivefifoempty), 1);

        // Asynchronous reset mid-transfer.
        for (int k = 0; k < 10; k++) tx_push(9'(9'h080 + k));
        for (int k = 0; k < 7; k++) rx_write(9'(9'h0C0 + k));
        @(negedge clock);
        chk("pre_reset_tx_count", 32'(transmitfifodatacount), 10);
        chk("pre_reset_rx_count", 32'(receivefifodatacount), 7);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_tx_count", 32'(transmitfifodatacount), 0);
        chk("async_rst_rx_count", 32'(receivefifodatacount), 0);
        chk("async_rst_rx_empty", 32'(receivefifoempty), 1);
        chk("async_rst_txvalid", 32'(txvalid), 0);
        chk("async_rst_rxready", 32'(rxready), 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("post_rst_rxready", 32'(rxready), 1);
        chk("post_rst_tx_count", 32'(transmitfifodatacount), 0);
        chk("post_rst_txvalid", 32'(txvalid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
